mr_chips_run_ctrl: RTL and testbench

//  Synthesizable run controller and trace capture for the mr_chips core.
//  - Sequences core reset, then counts run cycles.
//  - Stops on a cycle budget or on a halt (PC unchanged).
//  - Captures (pc_out, alu_result) pairs into a circular trace buffer, drained over a valid/ready port.
//  - Sits beside the core; replaces fixed-delay reset/finish timing with parametrised, observable control.

---
 rtl/mr_chips_run_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mr_chips_run_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mr_chips_run_ctrl.sv
// Run controller and trace capture for the mr_chips core: core reset sequencing, cycle budget / halt stop,
// circular (pc, alu) trace buffer. Optional macro MR_CHIPS_TRACE_FILTER_EN captures only PC changes.
module mr_chips_run_ctrl #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 5,
    parameter int MAX_CYCLES   = 75,
    parameter int HALT_CYCLES  = 4,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic [WIDTH-1:0]         alu_in,
    output logic                     core_reset,
    output logic                     run_active,
    output logic                     done,
    output logic [1:0]               done_reason,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_pc,
    output logic [WIDTH-1:0]         rd_alu,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int HC_W = $clog2(HALT_CYCLES + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RST = 2'b01, S_RUN = 2'b10, S_DONE = 2'b11} state_t;

    state_t             state_r, state_next_s;
    logic [RC_W-1:0]    rst_cnt_r;
    logic [HC_W-1:0]    halt_cnt_r, halt_next_s;
    logic [CNT_W-1:0]   cycle_count_r, cnt_inc_s;
    logic [WIDTH-1:0]   prev_pc_r;
    logic [1:0]         reason_r, reason_next_s;
    logic               core_reset_r, run_active_r, done_r;
    logic               clear_s, finish_s, first_run_s, in_run_s, wr_en_s, pop_s, full_s;
    logic [WIDTH-1:0]   mem_pc  [DEPTH];
    logic [WIDTH-1:0]   mem_alu [DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [AW:0]        count_r;
    logic               overflow_r;

    assign in_run_s    = (state_r == S_RUN);
    assign first_run_s = (cycle_count_r == {CNT_W{1'b0}});
    assign pop_s       = (count_r != {(AW+1){1'b0}}) && rd_ready;
    assign full_s      = (count_r == FULL_CNT);

    // Next state, saturating cycle increment, halt tracking and stop decision
    always_comb begin
        state_next_s  = state_r;
        clear_s       = 1'b0;
        finish_s      = 1'b0;
        reason_next_s = 2'b00;
        if (cycle_count_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cycle_count_r;
        end else begin
            cnt_inc_s = cycle_count_r + CNT_W'(1);
        end
        // The first RUN cycle has no predecessor, so it always counts as a PC change
        if (first_run_s) begin
            halt_next_s = {HC_W{1'b0}};
        end else if (pc_in == prev_pc_r) begin
            halt_next_s = halt_cnt_r + HC_W'(1);
        end else begin
            halt_next_s = {HC_W{1'b0}};
        end
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next_s = S_RST;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_RST: begin
                if (rst_cnt_r == RC_W'(RESET_CYCLES - 1)) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_RST;
                end
            end
            S_RUN: begin
                if (halt_next_s >= HC_W'(HALT_CYCLES)) begin
                    state_next_s  = S_DONE;
                    finish_s      = 1'b1;
                    reason_next_s = 2'b10;
                end else if (cnt_inc_s >= CNT_W'(MAX_CYCLES)) begin
                    state_next_s  = S_DONE;
                    finish_s      = 1'b1;
                    reason_next_s = 2'b01;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Control state, registered status outputs and run counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            rst_cnt_r     <= {RC_W{1'b0}};
            halt_cnt_r    <= {HC_W{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
            prev_pc_r     <= {WIDTH{1'b0}};
            reason_r      <= 2'b00;
            core_reset_r  <= 1'b1;
            run_active_r  <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            core_reset_r <= (state_next_s != S_RUN);
            run_active_r <= (state_next_s == S_RUN);
            done_r       <= (state_next_s == S_DONE);
            if (state_r == S_RST) begin
                rst_cnt_r <= rst_cnt_r + RC_W'(1);
            end else begin
                rst_cnt_r <= {RC_W{1'b0}};
            end
            if (clear_s) begin
                cycle_count_r <= {CNT_W{1'b0}};
                halt_cnt_r    <= {HC_W{1'b0}};
                reason_r      <= 2'b00;
            end else if (in_run_s) begin
                cycle_count_r <= cnt_inc_s;
                halt_cnt_r    <= halt_next_s;
                prev_pc_r     <= pc_in;
                if (finish_s) begin
                    reason_r <= reason_next_s;
                end
            end
        end
    end

`ifdef MR_CHIPS_TRACE_FILTER_EN
    logic [WIDTH-1:0] last_pc_r;

    // Most recently captured PC, so repeated PCs are not re-captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc_r <= {WIDTH{1'b0}};
        end else if (wr_en_s) begin
            last_pc_r <= pc_in;
        end
    end

    assign wr_en_s = in_run_s && (first_run_s || (pc_in != last_pc_r));
`else
    assign wr_en_s = in_run_s;
`endif

    // Trace pointers and occupancy; a write into a full buffer drops the oldest entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else if (clear_s) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s || (wr_en_s && full_s)) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (wr_en_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
            if (wr_en_s && !pop_s && !full_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else if (!wr_en_s && pop_s) begin
                count_r <= count_r - (AW+1)'(1);
            end
        end
    end

    // Trace storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_pc[wr_ptr_r]  <= pc_in;
            mem_alu[wr_ptr_r] <= alu_in;
        end
    end

    assign core_reset  = core_reset_r;
    assign run_active  = run_active_r;
    assign done        = done_r;
    assign done_reason = reason_r;
    assign cycle_count = cycle_count_r;
    assign rd_valid    = (count_r != {(AW+1){1'b0}});
    assign rd_pc       = mem_pc[rd_ptr_r];
    assign rd_alu      = mem_alu[rd_ptr_r];
    assign trace_count = count_r;
    assign overflow    = overflow_r;
endmodule

// File: tb/tb_mr_chips_run_ctrl.sv
// Self-checking bench for mr_chips_run_ctrl: table of complete runs scored against a reference trace queue,
// plus hand-written reset sequences.
module tb_mr_chips_run_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] alu_in = 16'h0000;
    logic        core_reset, run_active, done, rd_valid, overflow;
    logic        rd_ready = 1'b0;
    logic [1:0]  done_reason;
    logic [15:0] cycle_count, rd_pc, rd_alu;
    logic [4:0]  trace_count;

    int n_checks = 0;
    int n_errs = 0;
    int cur_row = -1;

    logic [15:0] model_pc[$];
    logic [15:0] model_alu[$];
    bit          m_ovf;

    typedef struct {
        int         hold_at;
        bit         ready;
        logic [1:0] reason;
        int         cycles;
        bit         ovf;
        int         tc;
        int         first_pc;
    } run_vec_t;

    run_vec_t vecs[5];

    mr_chips_run_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in),
        .core_reset(core_reset), .run_active(run_active), .done(done), .done_reason(done_reason),
        .cycle_count(cycle_count), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_alu(rd_alu), .trace_count(trace_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", nm, cur_row, act, exp);
        end
    endtask

    // Compare read side against the reference queue; retire the head if it will be popped at the next edge.
    task automatic sb_step();
        chk("rd_valid", 32'(rd_valid), 32'(model_pc.size() != 0));
        chk("trace_count", 32'(trace_count), 32'(model_pc.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (model_pc.size() != 0) begin
            chk("rd_pc", 32'(rd_pc), 32'(model_pc[0]));
            chk("rd_alu", 32'(rd_alu), 32'(model_alu[0]));
            if (rd_ready) begin
                void'(model_pc.pop_front());
                void'(model_alu.pop_front());
            end
        end
    endtask

    task automatic sb_push(input logic [15:0] p, input logic [15:0] a);
        model_pc.push_back(p);
        model_alu.push_back(a);
        if (model_pc.size() > DEPTH) begin
            void'(model_pc.pop_front());
            void'(model_alu.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic do_run(input run_vec_t v);
        int k, rst_hi, guard, g;
        logic [15:0] last_pc;
        k = 0; rst_hi = 0; guard = 0;
        last_pc = 16'h0000;
        model_pc.delete();
        model_alu.delete();
        m_ovf = 1'b0;
        rd_ready = v.ready;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && guard < 300) begin
            sb_step();
            start = 1'b0;
            if (core_reset === 1'b1) begin
                rst_hi++;
                if (rst_hi == 3) start = 1'b1;
            end
            if (run_active === 1'b1) begin
                k++;
                pc_in = (k - 1 <= v.hold_at) ? 16'(k - 1) : 16'(v.hold_at);
                alu_in = 16'(k * 5 + 4096);
                if (k == 3) start = 1'b1;
`ifdef MR_CHIPS_TRACE_FILTER_EN
                if (k == 1 || pc_in != last_pc) begin
                    sb_push(pc_in, alu_in);
                    last_pc = pc_in;
                end
`else
                sb_push(pc_in, alu_in);
`endif
            end
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("reached_done", 32'(done), 32'd1);
        chk("core_reset_cycles", 32'(rst_hi), 32'd5);
        chk("run_cycles_seen", 32'(k), 32'(v.cycles));
        chk("done_reason", 32'(done_reason), 32'(v.reason));
        chk("cycle_count", 32'(cycle_count), 32'(v.cycles));
        chk("core_reset_done", 32'(core_reset), 32'd1);
        chk("run_active_done", 32'(run_active), 32'd0);
        chk("overflow_end", 32'(overflow), 32'(v.ovf));
        chk("trace_count_end", 32'(trace_count), 32'(v.tc));
        rd_ready = 1'b1;
        g = 0;
        if (rd_valid === 1'b1) chk("first_popped_pc", 32'(rd_pc), 32'(v.first_pc));
        while (rd_valid === 1'b1 && g < DEPTH + 4) begin
            sb_step();
            @(negedge clk);
            g++;
        end
        rd_ready = 1'b0;
        chk("drained_model", 32'(model_pc.size()), 32'd0);
        chk("drained_count", 32'(trace_count), 32'd0);
        chk("reason_hold", 32'(done_reason), 32'(v.reason));
        chk("count_hold", 32'(cycle_count), 32'(v.cycles));
        chk("done_hold", 32'(done), 32'd1);
    endtask

    initial begin
        bit filt;
        int k, guard;
`ifdef MR_CHIPS_TRACE_FILTER_EN
        filt = 1'b1;
`else
        filt = 1'b0;
`endif
        //          hold_at ready reason  cycles ovf  tc                first_pc
        vecs[0] = '{1000, 1'b0, 2'b01, 75, 1'b1, 16,               59};
        vecs[1] = '{3,    1'b0, 2'b10, 8,  1'b0, filt ? 4 : 8,     0};
        vecs[2] = '{1000, 1'b1, 2'b01, 75, 1'b0, 1,                74};
        vecs[3] = '{20,   1'b0, 2'b10, 25, 1'b1, 16,               filt ? 5 : 9};
        vecs[4] = '{70,   1'b0, 2'b10, 75, 1'b1, 16,               filt ? 55 : 59};

        // Reset state, held and after release without start
        @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_run_active", 32'(run_active), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_core_reset", 32'(core_reset), 32'd1);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_rd_valid", 32'(rd_valid), 32'd0);
            chk("idle_trace_count", 32'(trace_count), 32'd0);
            chk("idle_reason", 32'(done_reason), 32'd0);
            chk("idle_cycle_count", 32'(cycle_count), 32'd0);
        end

        // Asynchronous reset in the middle of a run
        k = 0; guard = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < 10 && guard < 50) begin
            if (run_active === 1'b1) begin
                k++;
                pc_in = 16'(k + 100);
                alu_in = 16'(k);
            end
            guard++;
            @(negedge clk);
        end
        chk("mid_reached_run10", 32'(k), 32'd10);
        chk("mid_count_before", 32'(cycle_count), 32'd10);
        chk("mid_trace_before", 32'(trace_count), filt ? 32'd10 : 32'd10);
        reset = 1'b0;
        #1;
        chk("mid_core_reset", 32'(core_reset), 32'd1);
        chk("mid_run_active", 32'(run_active), 32'd0);
        chk("mid_trace_count", 32'(trace_count), 32'd0);
        chk("mid_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_cycle_count", 32'(cycle_count), 32'd0);
        @(negedge clk);
        chk("mid_idle_held", 32'(core_reset), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            cur_row = r;
            do_run(vecs[r]);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
